// File: rtl/logical_shifter_reg.sv
// Registered logical barrel shifter with a single-entry valid/ready output stage.
// Zero-fill left/right shifts; reports the last bit shifted out and an all-zero flag.
module logical_shifter_reg #(
    parameter int WIDTH   = 8,
    parameter int SHAMT_W = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [WIDTH-1:0]   di,
    input  logic [SHAMT_W-1:0] sel,
    input  logic               dir,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [WIDTH-1:0]   o,
    output logic               carry_out,
    output logic               zero,
    output logic               out_valid,
    input  logic               out_ready
);

    logic [WIDTH:0]   lext;
    logic [WIDTH:0]   rext;
    logic [WIDTH-1:0] res;
    logic             res_cy;
    logic             res_zero;
    logic             accept;

    // One guard bit beyond the word catches the last bit shifted out;
    // it stays 0 when nothing is shifted.
    always_comb begin
        lext = {1'b0, di} << sel;
        rext = {di, 1'b0} >> sel;
        res = lext[WIDTH-1:0];
        res_cy = lext[WIDTH];
        if (dir) begin
            res = rext[WIDTH:1];
            res_cy = rext[0];
        end
        res_zero = (res == '0);
    end

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o         <= '0;
            carry_out <= 1'b0;
            zero      <= 1'b1;
            out_valid <= 1'b0;
        end else if (accept) begin
            o         <= res;
            carry_out <= res_cy;
            zero      <= res_zero;
            out_valid <= 1'b1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_logical_shifter_reg.sv
// Directed self-checking bench for logical_shifter_reg.
// Each scenario task drives vectors and compares against hand-computed values.
module tb_logical_shifter_reg;

    logic       clk;
    logic       rst_n;
    logic [7:0] di;
    logic [1:0] sel;
    logic       dir;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] o;
    logic       carry_out;
    logic       zero;
    logic       out_valid;
    logic       out_ready;

    int checks;
    int failures;

    logical_shifter_reg #(.WIDTH(8), .SHAMT_W(2)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .di(di),
        .sel(sel),
        .dir(dir),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .o(o),
        .carry_out(carry_out),
        .zero(zero),
        .out_valid(out_valid),
        .out_ready(out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        di = 8'h00;
        sel = 2'd0;
        dir = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        #12;
        checks++;
        if (o !== 8'h00 || carry_out !== 1'b0 || zero !== 1'b1
            || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_state: o=%b c=%b z=%b v=%b want 0 0 1 0",
                     o, carry_out, zero, out_valid);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step();
        checks++;
        if (out_valid !== 1'b0 || o !== 8'h00 || zero !== 1'b1) begin
            failures++;
            $display("FAIL reset_hold: o=%b z=%b v=%b want 0 1 0",
                     o, zero, out_valid);
        end
    endtask

    task automatic test_sweep(input logic d, input logic [7:0] ev [4],
                              input logic ec [4]);
        for (int k = 0; k < 4; k++) begin
            di = 8'b10110010;
            sel = 2'(k);
            dir = d;
            in_valid = 1'b1;
            out_ready = 1'b1;
            step();
            checks++;
            if (o !== ev[k] || carry_out !== ec[k] || zero !== 1'b0
                || out_valid !== 1'b1) begin
                failures++;
                $display("FAIL sweep dir=%0d sel=%0d: o=%b c=%b z=%b v=%b want %b %b 0 1",
                         d, k, o, carry_out, zero, out_valid, ev[k], ec[k]);
            end
        end
        in_valid = 1'b0;
        step();
    endtask

    task automatic test_zero_flag();
        di = 8'b10000000;
        sel = 2'd1;
        dir = 1'b0;
        in_valid = 1'b1;
        out_ready = 1'b1;
        step();
        checks++;
        if (o !== 8'h00 || carry_out !== 1'b1 || zero !== 1'b1) begin
            failures++;
            $display("FAIL zero_left1: o=%b c=%b z=%b want 00000000 1 1",
                     o, carry_out, zero);
        end
        dir = 1'b1;
        sel = 2'd3;
        step();
        checks++;
        if (o !== 8'b00010000 || carry_out !== 1'b0 || zero !== 1'b0) begin
            failures++;
            $display("FAIL zero_right3: o=%b c=%b z=%b want 00010000 0 0",
                     o, carry_out, zero);
        end
        in_valid = 1'b0;
        step();
    endtask

    task automatic test_backpressure();
        di = 8'b10110010;
        sel = 2'd1;
        dir = 1'b0;
        in_valid = 1'b1;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            di = 8'(8'h11 * (k + 3));
            sel = 2'(k + 1);
            dir = k[0];
            #1;
            checks++;
            if (in_ready !== 1'b0) begin
                failures++;
                $display("FAIL bp_in_ready cyc%0d: got %b want 0", k, in_ready);
            end
            step();
            checks++;
            if (o !== 8'b01100100 || carry_out !== 1'b1 || zero !== 1'b0
                || out_valid !== 1'b1) begin
                failures++;
                $display("FAIL bp_hold cyc%0d: o=%b c=%b z=%b v=%b want 01100100 1 0 1",
                         k, o, carry_out, zero, out_valid);
            end
        end
        di = 8'h0F;
        sel = 2'd2;
        dir = 1'b0;
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL bp_release_ready: got %b want 1", in_ready);
        end
        step();
        checks++;
        if (o !== 8'h3C || carry_out !== 1'b0 || out_valid !== 1'b1) begin
            failures++;
            $display("FAIL bp_replace: o=%b c=%b v=%b want 00111100 0 1",
                     o, carry_out, out_valid);
        end
    endtask

    task automatic test_bubble();
        in_valid = 1'b0;
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL bubble_ready_before: got %b want 1", in_ready);
        end
        step();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL bubble_drain: v=%b r=%b want 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_async_reset();
        di = 8'b00000110;
        sel = 2'd1;
        dir = 1'b0;
        in_valid = 1'b1;
        out_ready = 1'b0;
        step();
        in_valid = 1'b0;
        checks++;
        if (o !== 8'b00001100 || out_valid !== 1'b1) begin
            failures++;
            $display("FAIL ar_pre: o=%b v=%b want 00001100 1", o, out_valid);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (o !== 8'h00 || out_valid !== 1'b0 || zero !== 1'b1
            || carry_out !== 1'b0) begin
            failures++;
            $display("FAIL ar_immediate: o=%b c=%b z=%b v=%b want 0 0 1 0",
                     o, carry_out, zero, out_valid);
        end
        @(negedge clk);
        rst_n = 1'b1;
        di = 8'b11000001;
        sel = 2'd2;
        dir = 1'b1;
        in_valid = 1'b1;
        out_ready = 1'b1;
        step();
        checks++;
        if (o !== 8'b00110000 || carry_out !== 1'b0 || zero !== 1'b0
            || out_valid !== 1'b1) begin
            failures++;
            $display("FAIL ar_resume: o=%b c=%b z=%b v=%b want 00110000 0 0 1",
                     o, carry_out, zero, out_valid);
        end
        in_valid = 1'b0;
        step();
    endtask

    initial begin
        logic [7:0] lv [4];
        logic       lc [4];
        logic [7:0] rv [4];
        logic       rc [4];
        checks = 0;
        failures = 0;
        lv = '{8'b10110010, 8'b01100100, 8'b11001000, 8'b10010000};
        lc = '{1'b0, 1'b1, 1'b0, 1'b1};
        rv = '{8'b10110010, 8'b01011001, 8'b00101100, 8'b00010110};
        rc = '{1'b0, 1'b0, 1'b1, 1'b0};
        test_reset();
        test_sweep(1'b0, lv, lc);
        test_sweep(1'b1, rv, rc);
        test_zero_flag();
        test_backpressure();
        test_bubble();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
